// File: rtl/seq_pkg.sv
// Shared encodings and constants for the serial pattern transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] PAT_0110     = 4'b0110;
  localparam logic       IDLE_LVL_DEF = 1'b0;

endpackage

// File: rtl/seq_piso_shift.sv
// W-bit parallel-load shift register, MSB first; presents the bit that follows the current MSB.
module seq_piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] pat_i,
  output logic         next_o
);

  logic [W-1:0] q_q, q_d;

  // Rotating rather than zero-filling keeps the whole pattern resident after a shift.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = pat_i;
    end else if (shift_i) begin
      q_d = {q_q[W-2:0], q_q[W-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign next_o = q_q[W-2];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched W-bit pattern MSB first, rep times, with GAP idle cycles between.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int   W        = 4,
  parameter int   RW       = 4,
  parameter int   GAP      = 2,
  parameter logic IDLE_LVL = IDLE_LVL_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  pat_in,
  input  logic [RW-1:0] rep_in,
  input  logic          abort,
  output logic          out,
  output logic          valid,
  output logic          busy,
  output logic          done,
  output state_e        dbg_state
);

  localparam int IW = $clog2(W);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_e        state_q;
  logic [W-1:0]  pat_q;
  logic [RW-1:0] rep_q;
  logic [IW-1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic          out_q, valid_q, busy_q, done_q;

  logic          accept, last_bit, more_reps;
  logic          sh_load, sh_shift, sh_next;
  logic [W-1:0]  sh_pat;

  // Handshake: start is a level sampled only in IDLE/DONE; abort overrides it on the same edge.
  always_comb begin
    accept    = (state_q == ST_IDLE || state_q == ST_DONE) && start && !abort;
    last_bit  = (state_q == ST_SEND) && (idx_q == '0);
    more_reps = rep_q > RW'(1);
    sh_load   = accept ||
                (!abort && ((last_bit && more_reps && (GAP == 0)) ||
                            (state_q == ST_GAP && gap_q == '0)));
    sh_shift  = !abort && (state_q == ST_SEND) && (idx_q != '0);
    sh_pat    = accept ? pat_in : pat_q;
  end

  seq_piso_shift #(.W(W)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .pat_i   (sh_pat),
    .next_o  (sh_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      out_q   <= IDLE_LVL;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        out_q   <= IDLE_LVL;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_q <= ST_SEND;
              pat_q   <= pat_in;
              rep_q   <= (rep_in == '0) ? RW'(1) : rep_in;
              idx_q   <= IW'(W - 1);
              out_q   <= pat_in[W-1];
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              out_q   <= IDLE_LVL;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          ST_SEND: begin
            if (idx_q != '0) begin
              idx_q <= idx_q - 1'b1;
              out_q <= sh_next;
            end else if (more_reps) begin
              rep_q <= rep_q - 1'b1;
              if (GAP == 0) begin
                idx_q <= IW'(W - 1);
                out_q <= pat_q[W-1];
              end else begin
                state_q <= ST_GAP;
                gap_q   <= GW'(GAP - 1);
                out_q   <= IDLE_LVL;
                valid_q <= 1'b0;
              end
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              out_q   <= IDLE_LVL;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
            end
          end
          ST_GAP: begin
            if (gap_q == '0) begin
              state_q <= ST_SEND;
              idx_q   <= IW'(W - 1);
              out_q   <= pat_q[W-1];
              valid_q <= 1'b1;
            end else begin
              gap_q <= gap_q - 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign out       = out_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one GAP=2 instance and one GAP=0 instance share the stimulus.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int W  = 4;
  localparam int RW = 4;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic [W-1:0]  pat_in = '0;
  logic [RW-1:0] rep_in = '0;

  logic   out_a, valid_a, busy_a, done_a;
  logic   out_b, valid_b, busy_b, done_b;
  state_e st_a, st_b;

  int   checks = 0;
  int   errors = 0;
  bit   sel_b  = 1'b0;
  logic [3:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  seq_pattern_tx #(.W(W), .RW(RW), .GAP(2), .IDLE_LVL(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_in(pat_in), .rep_in(rep_in),
    .abort(abort), .out(out_a), .valid(valid_a), .busy(busy_a), .done(done_a),
    .dbg_state(st_a)
  );

  seq_pattern_tx #(.W(W), .RW(RW), .GAP(0), .IDLE_LVL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .pat_in(pat_in), .rep_in(rep_in),
    .abort(abort), .out(out_b), .valid(valid_b), .busy(busy_b), .done(done_b),
    .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] obs_vec();
    return sel_b ? {done_b, busy_b, valid_b, out_b} : {done_a, busy_a, valid_a, out_a};
  endfunction

  // Expected vector per edge: {done, busy, valid, out}
  task automatic push_bits(input logic [W-1:0] p);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back({3'b011, p[i]});
  endtask

  task automatic push_rep(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_chk(input string tag);
    logic [3:0] e;
    step();
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: expected queue empty at t=%0t", tag, $time);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(obs_vec()), 32'(e));
    end
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) cycle_chk(tag);
  endtask

  task automatic launch(input string tag, input logic [W-1:0] p, input logic [RW-1:0] r);
    start  = 1'b1;
    pat_in = p;
    rep_in = r;
    cycle_chk(tag);
    start  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    step();
    check("rst_vec", 32'(obs_vec()), 32'h0);
    check("rst_state", 32'(st_a), 32'(ST_IDLE));
    rst_n = 1'b1;
    step();

    // 1: single frame
    push_bits(PAT_0110); push_rep(4'b1000, 1); push_rep(4'b0000, 2);
    launch("single", PAT_0110, 4'd1);
    drain("single");

    // 2: three repetitions with a two-cycle gap
    push_bits(PAT_0110); push_rep(4'b0100, 2);
    push_bits(PAT_0110); push_rep(4'b0100, 2);
    push_bits(PAT_0110); push_rep(4'b1000, 1); push_rep(4'b0000, 2);
    launch("rep3_gap", PAT_0110, 4'd3);
    drain("rep3_gap");

    // 3a: rep_in = 0 behaves as a single repetition
    push_bits(4'b1001); push_rep(4'b1000, 1); push_rep(4'b0000, 2);
    launch("rep0", 4'b1001, 4'd0);
    drain("rep0");

    // 3b: GAP = 0 instance, two back-to-back repetitions
    sel_b = 1'b1;
    push_bits(4'b1001); push_bits(4'b1001); push_rep(4'b1000, 1); push_rep(4'b0000, 4);
    launch("gap0", 4'b1001, 4'd2);
    drain("gap0");
    sel_b = 1'b0;
    step();

    // 4: start held high; mid-frame pattern change must not leak out
    push_bits(PAT_0110); push_rep(4'b1000, 1);
    push_bits(PAT_0110); push_rep(4'b1000, 1); push_rep(4'b0000, 2);
    start = 1'b1; pat_in = PAT_0110; rep_in = 4'd1;
    cycle_chk("hold");
    pat_in = 4'b1111;
    cycle_chk("hold");
    cycle_chk("hold");
    pat_in = PAT_0110;
    cycle_chk("hold");
    cycle_chk("hold_done");
    cycle_chk("hold_restart");
    start = 1'b0; pat_in = 4'b1111;
    drain("hold");

    // 5a: abort on the second bit
    exp_q.push_back(4'b0110); push_rep(4'b0000, 6);
    launch("abort", PAT_0110, 4'd2);
    abort = 1'b1;
    cycle_chk("abort_edge");
    abort = 1'b0;
    check("abort_state", 32'(st_a), 32'(ST_IDLE));
    drain("abort_after");

    // 5b: abort with start in IDLE
    push_rep(4'b0000, 4);
    start = 1'b1; abort = 1'b1; pat_in = 4'b1111; rep_in = 4'd1;
    cycle_chk("abort_start");
    start = 1'b0; abort = 1'b0;
    drain("abort_start");

    // 6: async reset in the gap, then a clean frame
    push_bits(PAT_0110); push_rep(4'b0100, 1);
    launch("rst_mid", PAT_0110, 4'd2);
    drain("rst_mid");
    check("gap_state", 32'(st_a), 32'(ST_GAP));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_vec", 32'(obs_vec()), 32'h0);
    check("async_rst_state", 32'(st_a), 32'(ST_IDLE));
    #2;
    rst_n = 1'b1;
    push_bits(4'b1011); push_rep(4'b1000, 1); push_rep(4'b0000, 2);
    launch("post_rst", 4'b1011, 4'd1);
    drain("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
